// File: rtl/reg_file_sb_pkg.sv
// Shared configuration for the register file: default sizes and the address/data types.
package reg_file_sb_pkg;
  localparam int DATA_WIDTH   = 32;
  localparam int NUM_REGISTER = 32;
  localparam int REG_ADDR_W   = $clog2(NUM_REGISTER);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  // Largest pending count a PEND_W-bit counter can hold.
  function automatic int pend_max(input int pend_w);
    return (1 << pend_w) - 1;
  endfunction
endpackage

// File: rtl/reg_file_sb_if.sv
// Read, write-back and issue-claim signals between the pipeline and the register file.
interface reg_file_sb_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_RD_PORTS*AW-1:0]         rs_addr_i;
  logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rs_data_o;
  logic [NUM_RD_PORTS-1:0]            rs_busy_o;
  logic                               wb_we_i;
  logic [AW-1:0]                      wb_addr_i;
  logic [DATA_WIDTH-1:0]              wb_data_i;
  logic                               issue_valid_i;
  logic [AW-1:0]                      issue_rd_addr_i;
  logic                               issue_ready_o;
  logic                               pend_any_o;

  modport master (
    output rs_addr_i, wb_we_i, wb_addr_i, wb_data_i, issue_valid_i, issue_rd_addr_i,
    input  rs_data_o, rs_busy_o, issue_ready_o, pend_any_o
  );

  modport slave (
    input  rs_addr_i, wb_we_i, wb_addr_i, wb_data_i, issue_valid_i, issue_rd_addr_i,
    output rs_data_o, rs_busy_o, issue_ready_o, pend_any_o
  );
endinterface

// File: rtl/rf_pend_counter.sv
// Saturating up/down count of in-flight writes to one register; never wraps or underflows.
module rf_pend_counter #(
  parameter int PEND_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic sat,
  output logic nonzero,
  output logic last
);
  logic [PEND_W-1:0] cnt;

  assign sat     = (cnt == '1);
  assign nonzero = (cnt != '0);
  assign last    = (cnt == PEND_W'(1));

  // Simultaneous claim and retire cancel out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && !dec && !sat) begin
      cnt <= cnt + PEND_W'(1);
    end else if (dec && !inc && nonzero) begin
      cnt <= cnt - PEND_W'(1);
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// Register file with async read ports, one write-back port and a pending-write scoreboard.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_WIDTH   = reg_file_sb_pkg::DATA_WIDTH,
  parameter int NUM_REGS     = reg_file_sb_pkg::NUM_REGISTER,
  parameter int NUM_RD_PORTS = 2,
  parameter int PEND_W       = 2
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  reg_file_sb_if.slave  bus
);
  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS-1:1];
  logic [NUM_REGS-1:0]   sat_vec;
  logic [NUM_REGS-1:0]   nz_vec;
  logic [NUM_REGS-1:0]   last_vec;
  logic                  issue_ready;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else if (bus.wb_we_i && bus.wb_addr_i != '0) begin
      regs[bus.wb_addr_i] <= bus.wb_data_i;
    end
  end

  // Register 0 has no counter: never busy, never saturated.
  assign sat_vec[0]  = 1'b0;
  assign nz_vec[0]   = 1'b0;
  assign last_vec[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
    logic inc;
    logic dec;
    assign inc = bus.issue_valid_i && issue_ready && (bus.issue_rd_addr_i == AW'(r));
    assign dec = bus.wb_we_i && (bus.wb_addr_i == AW'(r));

    rf_pend_counter #(.PEND_W(PEND_W)) u_cnt (
      .clk     (clk_i),
      .rst_n   (rst_n_i),
      .inc     (inc),
      .dec     (dec),
      .sat     (sat_vec[r]),
      .nonzero (nz_vec[r]),
      .last    (last_vec[r])
    );
  end

  assign issue_ready       = (bus.issue_rd_addr_i == '0) || !sat_vec[bus.issue_rd_addr_i];
  assign bus.issue_ready_o = issue_ready;
  assign bus.pend_any_o    = |nz_vec;

  for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] arr_dat;
    logic                  hit;

    assign addr    = bus.rs_addr_i[k*AW +: AW];
    assign arr_dat = (addr == '0) ? '0 : regs[addr];
`ifdef REGFILE_BYPASS_EN
    assign hit = bus.wb_we_i && (bus.wb_addr_i == addr) && (addr != '0);
`else
    assign hit = 1'b0;
`endif
    // A forwarded write that retires the last pending claim clears the hazard this cycle.
    assign bus.rs_data_o[k*DATA_WIDTH +: DATA_WIDTH] = hit ? bus.wb_data_i : arr_dat;
    assign bus.rs_busy_o[k] = nz_vec[addr] && !(hit && last_vec[addr]);
  end

`ifndef SYNTHESIS
  logic claim_same;
  assign claim_same = bus.issue_valid_i && issue_ready && (bus.issue_rd_addr_i == bus.wb_addr_i);

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(bus.wb_we_i && bus.wb_addr_i != '0 && !nz_vec[bus.wb_addr_i] && !claim_same))
    else $error("write-back to register %0d with no pending claim", bus.wb_addr_i);
`endif
endmodule
